// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// ------------------
// Arbitrates between the ALU and load writeback paths for the single
// register-file write port, and keeps a per-register busy scoreboard for
// the issue stage. Writes to R15 are steered to the PC write port instead
// of the register file.
//
// Handshake (both requesters): a request is accepted on a rising edge when
// its valid and ready are both high. Ready is combinational from the
// current valids and arbiter state, is never high while its own valid is
// low, and is forced low while reset_n is low. At most one request is
// accepted per cycle.
//
// Arbitration: in NORMAL the load path wins a collision. The ALU path
// counts consecutive losses; on reaching STARVE_LIMIT the arbiter moves to
// FORCE_ALU, where the ALU wins a collision. It returns to NORMAL on the
// edge where the ALU request is accepted. A lone requester always wins.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   alu_valid/alu_rd/alu_data    ALU writeback request; alu_ready accept
//   mem_valid/mem_rd/mem_data    load writeback request; mem_ready accept
//   we3/a3/wd3                   registered register-file write drive
//   pc_we/pc_wdata               registered R15 (PC) write drive
//   claim_valid/claim_rd         issue stage reserves a destination
//   busy[14:0]                   bit n = register n has a pending write
//   state_dbg                    arbiter state (0 NORMAL, 1 FORCE_ALU)
//   starve_cnt_dbg               ALU consecutive-loss counter

module regfile_wb_arbiter #(
  parameter  int STARVE_LIMIT = 3,
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alu_valid,
  input  logic [3:0]       alu_rd,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [3:0]       mem_rd,
  input  logic [31:0]      mem_data,
  output logic             mem_ready,
  output logic             we3,
  output logic [3:0]       a3,
  output logic [31:0]      wd3,
  output logic             pc_we,
  output logic [31:0]      pc_wdata,
  input  logic             claim_valid,
  input  logic [3:0]       claim_rd,
  output logic [14:0]      busy,
  output logic             state_dbg,
  output logic [CNT_W-1:0] starve_cnt_dbg
);

  typedef enum logic {
    ST_NORMAL    = 1'b0,
    ST_FORCE_ALU = 1'b1
  } arb_state_t;

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic             acc;
  logic [3:0]       acc_rd;
  logic [31:0]      acc_data;
  logic [14:0]      busy_nxt;

  // Arbiter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grant and next-state logic
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;

    if (reset_n) begin
      if (alu_valid && mem_valid) begin
        if (state == ST_FORCE_ALU) alu_ready = 1'b1;
        else                       mem_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end

    if (alu_ready) begin
      cnt_nxt   = '0;
      state_nxt = ST_NORMAL;
    end else if (!alu_valid) begin
      // Losses must be consecutive; an idle ALU cycle restarts the count.
      // The state itself stays put until the ALU is actually served.
      cnt_nxt = '0;
    end else if (cnt >= CNT_W'(STARVE_LIMIT - 1)) begin
      // This loss reaches the limit: saturate and force the ALU next.
      cnt_nxt   = CNT_W'(STARVE_LIMIT);
      state_nxt = ST_FORCE_ALU;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  assign acc      = alu_ready | mem_ready;
  assign acc_rd   = alu_ready ? alu_rd   : mem_rd;
  assign acc_data = alu_ready ? alu_data : mem_data;

  // Write drive, one cycle after acceptance. Address/data registers only
  // load when their port is written, so they hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3      <= 1'b0;
      a3       <= '0;
      wd3      <= '0;
      pc_we    <= 1'b0;
      pc_wdata <= '0;
    end else begin
      we3   <= 1'b0;
      pc_we <= 1'b0;
      if (acc) begin
        if (acc_rd == 4'd15) begin
          pc_we    <= 1'b1;
          pc_wdata <= acc_data;
        end else begin
          we3 <= 1'b1;
          a3  <= acc_rd;
          wd3 <= acc_data;
        end
      end
    end
  end

  // Busy scoreboard: clear on the register-file write, then apply the claim
  // so a same-edge claim of the register being written keeps it busy.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < 15; i++) begin
      if (we3 && (a3 == 4'(i)))                busy_nxt[i] = 1'b0;
      if (claim_valid && (claim_rd == 4'(i)))  busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  assign state_dbg      = state;
  assign starve_cnt_dbg = cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// ---------------------
// Directed bench for regfile_wb_arbiter (STARVE_LIMIT = 3). A table of
// per-cycle vectors with hand-computed readies and post-edge outputs drives
// the main function; a hand-written sequence covers reset mid-transfer and
// the first post-reset request. Register-file writes are also tracked
// through an expected queue popped by a monitor.

module tb_regfile_wb_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  logic        alu_valid, mem_valid, claim_valid;
  logic [3:0]  alu_rd, mem_rd, claim_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        we3, pc_we;
  logic [3:0]  a3;
  logic [31:0] wd3, pc_wdata;
  logic [14:0] busy;
  logic        state_dbg;
  logic [1:0]  starve_cnt_dbg;

  regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
    .we3            (we3),
    .a3             (a3),
    .wd3            (wd3),
    .pc_we          (pc_we),
    .pc_wdata       (pc_wdata),
    .claim_valid    (claim_valid),
    .claim_rd       (claim_rd),
    .busy           (busy),
    .state_dbg      (state_dbg),
    .starve_cnt_dbg (starve_cnt_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every observed register-file write must match the next expected one.
  always @(negedge clk) begin
    if (reset_n && we3) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {28'd0, a3}, 32'hFFFF_FFFF);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("wr_q_a3",  {28'd0, a3}, {28'd0, e[35:32]});
        check("wr_q_wd3", wd3, e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                       input logic cv, input logic [3:0] crd);
    alu_valid = av;  alu_rd = ard; alu_data = ad;
    mem_valid = mv;  mem_rd = mrd; mem_data = md;
    claim_valid = cv; claim_rd = crd;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        av;  logic [3:0] ard; logic [31:0] ad;
    logic        mv;  logic [3:0] mrd; logic [31:0] md;
    logic        cv;  logic [3:0] crd;
    logic        ear; logic       emr;
    logic        ewe; logic [3:0] ea3; logic [31:0] ewd;
    logic        epw; logic [31:0] epd;
    logic [14:0] eb;  logic       est; logic [1:0] ecnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  initial begin
    // alu    | mem     | claim || ar mr || we a3 wd3 | pcwe pcwd | busy st cnt
    vecs[0]  = '{1'b1,4'd3,32'hAA,     1'b0,4'd0,32'h0,     1'b0,4'd0,  1'b1,1'b0, 1'b1,4'd3,32'hAA,   1'b0,32'h0,    15'h0000,1'b0,2'd0};
    vecs[1]  = '{1'b0,4'd0,32'h0,      1'b1,4'd15,32'h1000, 1'b0,4'd0,  1'b0,1'b1, 1'b0,4'd3,32'hAA,   1'b1,32'h1000, 15'h0000,1'b0,2'd0};
    vecs[2]  = '{1'b0,4'd0,32'h0,      1'b0,4'd0,32'h0,     1'b1,4'd15, 1'b0,1'b0, 1'b0,4'd3,32'hAA,   1'b0,32'h1000, 15'h0000,1'b0,2'd0};
    vecs[3]  = '{1'b0,4'd0,32'h0,      1'b0,4'd0,32'h0,     1'b1,4'd5,  1'b0,1'b0, 1'b0,4'd3,32'hAA,   1'b0,32'h1000, 15'h0020,1'b0,2'd0};
    vecs[4]  = '{1'b1,4'd5,32'h55,     1'b0,4'd0,32'h0,     1'b0,4'd0,  1'b1,1'b0, 1'b1,4'd5,32'h55,   1'b0,32'h1000, 15'h0020,1'b0,2'd0};
    vecs[5]  = '{1'b0,4'd0,32'h0,      1'b0,4'd0,32'h0,     1'b0,4'd0,  1'b0,1'b0, 1'b0,4'd5,32'h55,   1'b0,32'h1000, 15'h0000,1'b0,2'd0};
    vecs[6]  = '{1'b0,4'd0,32'h0,      1'b0,4'd0,32'h0,     1'b1,4'd7,  1'b0,1'b0, 1'b0,4'd5,32'h55,   1'b0,32'h1000, 15'h0080,1'b0,2'd0};
    vecs[7]  = '{1'b1,4'd7,32'h77,     1'b0,4'd0,32'h0,     1'b1,4'd9,  1'b1,1'b0, 1'b1,4'd7,32'h77,   1'b0,32'h1000, 15'h0280,1'b0,2'd0};
    vecs[8]  = '{1'b0,4'd0,32'h0,      1'b0,4'd0,32'h0,     1'b1,4'd7,  1'b0,1'b0, 1'b0,4'd7,32'h77,   1'b0,32'h1000, 15'h0280,1'b0,2'd0};
    vecs[9]  = '{1'b1,4'd4,32'h44,     1'b1,4'd2,32'h22,    1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd2,32'h22,   1'b0,32'h1000, 15'h0280,1'b0,2'd1};
    vecs[10] = '{1'b1,4'd4,32'h44,     1'b1,4'd6,32'h66,    1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd6,32'h66,   1'b0,32'h1000, 15'h0280,1'b0,2'd2};
    vecs[11] = '{1'b1,4'd4,32'h44,     1'b1,4'd8,32'h88,    1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd8,32'h88,   1'b0,32'h1000, 15'h0280,1'b1,2'd3};
    vecs[12] = '{1'b1,4'd4,32'h44,     1'b1,4'd10,32'hA0,   1'b0,4'd0,  1'b1,1'b0, 1'b1,4'd4,32'h44,   1'b0,32'h1000, 15'h0280,1'b0,2'd0};
    vecs[13] = '{1'b0,4'd0,32'h0,      1'b1,4'd10,32'hA0,   1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd10,32'hA0,  1'b0,32'h1000, 15'h0280,1'b0,2'd0};
    vecs[14] = '{1'b1,4'd15,32'hDEAD,  1'b0,4'd0,32'h0,     1'b1,4'd15, 1'b1,1'b0, 1'b0,4'd10,32'hA0,  1'b1,32'hDEAD, 15'h0280,1'b0,2'd0};
    vecs[15] = '{1'b1,4'd12,32'hCC,    1'b1,4'd1,32'h11,    1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd1,32'h11,   1'b0,32'hDEAD, 15'h0280,1'b0,2'd1};
    vecs[16] = '{1'b0,4'd0,32'h0,      1'b1,4'd1,32'h12,    1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd1,32'h12,   1'b0,32'hDEAD, 15'h0280,1'b0,2'd0};
    vecs[17] = '{1'b1,4'd12,32'hCC,    1'b1,4'd3,32'h33,    1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd3,32'h33,   1'b0,32'hDEAD, 15'h0280,1'b0,2'd1};
    vecs[18] = '{1'b1,4'd12,32'hCC,    1'b1,4'd3,32'h34,    1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd3,32'h34,   1'b0,32'hDEAD, 15'h0280,1'b0,2'd2};
    vecs[19] = '{1'b1,4'd12,32'hCC,    1'b1,4'd3,32'h35,    1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd3,32'h35,   1'b0,32'hDEAD, 15'h0280,1'b1,2'd3};
    vecs[20] = '{1'b0,4'd0,32'h0,      1'b0,4'd0,32'h0,     1'b0,4'd0,  1'b0,1'b0, 1'b0,4'd3,32'h35,   1'b0,32'hDEAD, 15'h0280,1'b1,2'd0};
    vecs[21] = '{1'b0,4'd0,32'h0,      1'b1,4'd11,32'hBB,   1'b0,4'd0,  1'b0,1'b1, 1'b1,4'd11,32'hBB,  1'b0,32'hDEAD, 15'h0280,1'b1,2'd0};
    vecs[22] = '{1'b1,4'd12,32'hCC,    1'b1,4'd13,32'hD0,   1'b0,4'd0,  1'b1,1'b0, 1'b1,4'd12,32'hCC,  1'b0,32'hDEAD, 15'h0280,1'b0,2'd0};
  end

  // ---------------- test ----------------
  initial begin
    reset_n = 1'b0;
    drive(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b1, 4'd3);

    // Reset state, with both valids high: no grant allowed.
    #3;
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_we3",       {31'd0, we3},       32'd0);
    check("rst_pc_we",     {31'd0, pc_we},     32'd0);
    check("rst_a3",        {28'd0, a3},        32'd0);
    check("rst_wd3",       wd3,                32'd0);
    check("rst_pc_wdata",  pc_wdata,           32'd0);
    check("rst_busy",      {17'd0, busy},      32'd0);
    check("rst_state",     {31'd0, state_dbg}, 32'd0);
    check("rst_cnt",       {30'd0, starve_cnt_dbg}, 32'd0);

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md,
            vecs[i].cv, vecs[i].crd);
      #1;
      check($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].ear});
      check($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].emr});
      if (vecs[i].ewe) exp_q.push_back({vecs[i].ea3, vecs[i].ewd});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we3", i),      {31'd0, we3},      {31'd0, vecs[i].ewe});
      check($sformatf("v%0d_a3", i),       {28'd0, a3},       {28'd0, vecs[i].ea3});
      check($sformatf("v%0d_wd3", i),      wd3,               vecs[i].ewd);
      check($sformatf("v%0d_pc_we", i),    {31'd0, pc_we},    {31'd0, vecs[i].epw});
      check($sformatf("v%0d_pc_wdata", i), pc_wdata,          vecs[i].epd);
      check($sformatf("v%0d_busy", i),     {17'd0, busy},     {17'd0, vecs[i].eb});
      check($sformatf("v%0d_state", i),    {31'd0, state_dbg}, {31'd0, vecs[i].est});
      check($sformatf("v%0d_cnt", i),      {30'd0, starve_cnt_dbg}, {30'd0, vecs[i].ecnt});
    end

    // Reset asserted mid-transfer while we3 is high and the counter is live.
    @(negedge clk);
    drive(1'b1, 4'd6, 32'h66, 1'b1, 4'd6, 32'h61, 1'b1, 4'd6);
    #1;
    check("mid_mem_ready", {31'd0, mem_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("mid_we3",  {31'd0, we3},  32'd1);
    check("mid_cnt",  {30'd0, starve_cnt_dbg}, 32'd1);
    check("mid_busy", {17'd0, busy}, 32'h02C0);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_we3",       {31'd0, we3},       32'd0);
    check("arst_busy",      {17'd0, busy},      32'd0);
    check("arst_cnt",       {30'd0, starve_cnt_dbg}, 32'd0);
    check("arst_state",     {31'd0, state_dbg}, 32'd0);
    check("arst_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("arst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("arst_a3",        {28'd0, a3},        32'd0);
    check("arst_wd3",       wd3,                32'd0);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    check("arst_hold_we3", {31'd0, we3}, 32'd0);

    // First request after reset release is accepted normally.
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 4'd1, 32'h1234, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #1;
    check("post_alu_ready", {31'd0, alu_ready}, 32'd1);
    exp_q.push_back({4'd1, 32'h1234});
    @(posedge clk);
    #1;
    check("post_we3", {31'd0, we3}, 32'd1);
    check("post_a3",  {28'd0, a3},  32'd1);
    check("post_wd3", wd3,          32'h1234);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    check("post_idle_we3", {31'd0, we3}, 32'd0);

    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: number of consecutive cycles the ALU requester may lose arbitration before it is forced to win.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports alu_valid in 1, alu_rd in 4, alu_data in 32: ALU writeback request, destination register, result.
REQ-005 SHALL have port alu_ready  out  1  ALU request accepted this cycle.
REQ-006 SHALL have ports mem_valid in 1, mem_rd in 4, mem_data in 32: load writeback request, destination register, data.
REQ-007 SHALL have port mem_ready  out  1  load request accepted this cycle.
REQ-008 SHALL have ports we3 out 1, a3 out 4, wd3 out 32: register-file write port drive, registered.
REQ-009 SHALL have ports pc_we out 1, pc_wdata out 32: R15 (PC) write drive, registered.
REQ-010 SHALL have ports claim_valid in 1, claim_rd in 4: issue stage reserves a destination register.
REQ-011 SHALL have port busy  out  15  bit n = register n has a pending write; registered.

Function
REQ-012 SHALL accept at most one request per cycle; a request is accepted when valid and ready are both high at a rising edge.
REQ-013 SHALL compute alu_ready/mem_ready combinationally from the current valids and arbiter state; a ready SHALL never assert while its valid is low.
REQ-014 SHALL implement the arbiter FSM: state NORMAL, where mem wins when both are valid; state FORCE_ALU, where alu wins when both are valid.
REQ-015 SHALL count cycles where alu_valid=1 and alu loses; reaching STARVE_LIMIT SHALL move NORMAL->FORCE_ALU on that edge.
REQ-016 SHALL leave FORCE_ALU for NORMAL and clear the counter on the edge where the ALU request is accepted.
REQ-017 SHALL clear the counter on any cycle with alu_valid=0 or ALU accepted; a lone requester always wins regardless of state.
REQ-018 SHALL drive the accepted request to the outputs one cycle after acceptance (latency 1); for rd 0-14: we3=1, a3=rd, wd3=data, pc_we=0.
REQ-019 SHALL, for rd=15, drive pc_we=1 and pc_wdata=data with we3=0; a3/wd3 hold their previous values.
REQ-020 SHALL drive we3=0 and pc_we=0 in any cycle following a cycle with no acceptance; a3, wd3 and pc_wdata hold.
REQ-021 SHALL set busy[claim_rd] on the edge where claim_valid=1 and claim_rd<=14; claim_rd=15 SHALL be ignored.
REQ-022 SHALL clear busy[a3] on the edge where we3=1 (coincident with the register-file write).
REQ-023 SHALL leave the bit set when a claim and a clear target the same register on the same edge (set wins).
REQ-024 SHALL leave busy unchanged when a claim targets an already-busy register; no error is flagged.
REQ-025 SHALL not check busy before acceptance; hazard stalling is the issue stage's responsibility.

Reset
REQ-026 SHALL, while reset_n=0, force we3=0, a3=0, wd3=0, pc_we=0, pc_wdata=0, busy=0, state NORMAL and starve counter 0, asynchronously.
REQ-027 SHALL hold alu_ready=mem_ready=0 while reset_n=0; any request in flight at reset assertion is dropped.
REQ-028 SHALL resume arbitration on the first rising edge after reset_n deasserts.

Verification
REQ-029 SHALL be verified with: alu only, rd=3, data=0x0000_00AA -> alu_ready=1 the same cycle; next cycle we3=1, a3=3, wd3=0xAA.
REQ-030 SHALL be verified with: both valid for 4 cycles, STARVE_LIMIT=3, mem held valid -> mem accepted cycles 0-2, alu accepted cycle 3, state returns to NORMAL.
REQ-031 SHALL be verified with: mem rd=15, data=0x0000_1000 -> next cycle pc_we=1, pc_wdata=0x1000, we3=0.
REQ-032 SHALL be verified with: claim rd=5, then alu write rd=5 -> busy[5]=1 after the claim edge and 0 after the we3 edge; a same-edge re-claim keeps it 1.
REQ-033 SHALL be verified with: reset_n pulled low mid-transfer while we3=1 -> we3, busy and counter read 0 immediately; first post-reset request accepted normally.
REQ-034 SHALL be verified with: claim rd=15 -> busy stays 0x0000.
